i2c_api_arbiter: RTL and testbench
==================================

I2C_API_ARBITER -- requirements
Module: i2c_api_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 2000000, is the maximum number of cycles per granted transaction before abort.
REQ-002 Parameter CNT_W, default 24, is the width of the timeout counter.
REQ-003 clk  input  1  is the single system clock; all logic is on the rising edge.
REQ-004 rst_n  input  1  is the reset: synchronous, active-low.
REQ-005 r0_req, r1_req  input  1 each  are the requester transaction requests, held high until the matching done pulse.
REQ-006 r0_address, r1_address  input  7 each  carry the requester I2C 7-bit slave address.
REQ-007 r0_cmd, r1_cmd  input  8 each  carry the requester command byte.
REQ-008 r0_data, r1_data  input  8 each  carry the requester first data byte.
REQ-009 r0_data2, r1_data2  input  8 each  carry the requester second data byte.
REQ-010 r0_double, r1_double  input  1 each  request that the second data byte be sent when high.
REQ-011 r0_done, r1_done  output  1 each  are one-cycle completion pulses.
REQ-012 r0_error, r1_error  output  1 each  report the transaction status; each is valid only in the cycle its done pulse is high.
REQ-013 api_enable  output  1  is the start strobe to the I2C API.
REQ-014 api_address  output  7  is the latched address.
REQ-015 api_cmd  output  8  is the latched command byte.
REQ-016 api_data  output  8  is the latched first data byte.
REQ-017 api_data2  output  8  is the latched second data byte.
REQ-018 api_double  output  1  is the latched double-data flag.
REQ-019 api_complete  input  1  comes from the I2C API: high = idle, low = transaction in progress.
REQ-020 api_error  input  1  comes from the I2C API: error status, sampled at completion.
REQ-021 grant  output  1  is the index of the current or last granted requester.

Function
REQ-022 The FSM SHALL have these states:
- IDLE
- ISSUE
- WAIT_DONE
- RESPOND
REQ-023 IDLE, arbitration and latching:
- Arbitration is evaluated only when at least one rN_req=1 and api_complete=1.
- If only one requester is asserted, it wins.
- If both are asserted, the requester not equal to grant wins (round-robin).
- On a win, grant is updated, the winner's address/cmd/data/data2/double are latched into the api_* outputs, the timeout counter is cleared, and the FSM moves to ISSUE.
REQ-024 ISSUE:
- api_enable=1 is held until api_complete=0 is sampled.
- On that sample: api_enable goes to 0 on the next edge and the FSM moves to WAIT_DONE.
REQ-025 WAIT_DONE: on api_complete=1, the FSM latches api_error into an internal status and moves to RESPOND.
REQ-026 RESPOND (one cycle):
- The granted requester's rN_done=1 and rN_error=status; the other requester's outputs stay 0.
- The FSM returns to IDLE.
REQ-027 The timeout counter SHALL increment every cycle in ISSUE and WAIT_DONE.
REQ-028 Timeout: when the counter reaches TIMEOUT_CYCLES-1, the FSM SHALL force api_enable=0, set status=1, and go to RESPOND, regardless of api_complete.
REQ-029 The api_* data outputs SHALL remain stable from IDLE exit until the next grant; requester input changes after latching have no effect.
REQ-030 A requester still high in the cycle after its done pulse SHALL be treated as a new request and arbitrated normally (round-robin then favours the other requester).
REQ-031 A request arriving while the FSM is not IDLE SHALL wait; requests are never dropped while held high.
REQ-032 IDLE with requests pending but api_complete=0 SHALL remain IDLE (the API is busy externally).
REQ-033 Latency SHALL be 1 cycle from rN_req sampled to api_enable=1, given an idle API and no contention.
REQ-034 Simultaneous api_complete rise and timeout SHALL resolve as a normal completion with the api_error status.

Reset
REQ-035 When rst_n=0 at a clock edge, the block SHALL reset as follows:
- State = IDLE; any transaction in progress is abandoned and no done pulse is produced.
- api_enable=0 and all api_* data outputs = 0.
- r0_done=r1_done=0 and r0_error=r1_error=0.
- grant=1, so r0 wins the first contention.
- Timeout counter = 0 and status = 0.

Verification
REQ-036 Single request: r0_req with address=0x3C, cmd=0x00, data=0xAF, double=0, API model completing after 40 cycles -> api_address=0x3C, api_data=0xAF, api_enable high until api_complete falls, then one r0_done pulse with r0_error=0.
REQ-037 Contention: r0_req and r1_req both asserted from reset and held -> service order r0, r1, r0, r1; exactly one done pulse per transaction.
REQ-038 Error: API model returns api_error=1 at completion for r1 -> r1_done=1 and r1_error=1 in the same cycle; r0 outputs stay 0.
REQ-039 Timeout: TIMEOUT_CYCLES=100 and api_complete stuck low -> r0_done with r0_error=1 exactly 100 cycles after entering ISSUE, and api_enable=0 from then on.
REQ-040 Reset mid-transaction: rst_n=0 for 1 cycle while in WAIT_DONE -> all outputs return to reset values, no done pulse, and the next contention grants r0.

Source files
------------

// File: rtl/i2c_api_arbiter_if.sv
// Bundle between two I2C requesters, the arbiter, and the shared I2C API engine.
// master = arbiter side, slave = requesters plus API engine.
interface i2c_api_arbiter_if;
  logic       r0_req,     r1_req;
  logic [6:0] r0_address, r1_address;
  logic [7:0] r0_cmd,     r1_cmd;
  logic [7:0] r0_data,    r1_data;
  logic [7:0] r0_data2,   r1_data2;
  logic       r0_double,  r1_double;
  logic       r0_done,    r1_done;
  logic       r0_error,   r1_error;

  logic       api_enable;
  logic [6:0] api_address;
  logic [7:0] api_cmd;
  logic [7:0] api_data;
  logic [7:0] api_data2;
  logic       api_double;
  logic       api_complete;
  logic       api_error;
  logic       grant;

  modport master (
    input  r0_req, r1_req, r0_address, r1_address, r0_cmd, r1_cmd,
           r0_data, r1_data, r0_data2, r1_data2, r0_double, r1_double,
           api_complete, api_error,
    output r0_done, r1_done, r0_error, r1_error,
           api_enable, api_address, api_cmd, api_data, api_data2, api_double, grant
  );

  modport slave (
    output r0_req, r1_req, r0_address, r1_address, r0_cmd, r1_cmd,
           r0_data, r1_data, r0_data2, r1_data2, r0_double, r1_double,
           api_complete, api_error,
    input  r0_done, r1_done, r0_error, r1_error,
           api_enable, api_address, api_cmd, api_data, api_data2, api_double, grant
  );
endinterface

// File: rtl/i2c_api_arbiter.sv
// Round-robin arbiter sharing one I2C API engine between two requesters,
// with a per-transaction timeout that reports an error to the granted requester.
//
// state     | meaning
// IDLE      | arbitrate when a request is pending and the API is idle
// ISSUE     | api_enable high until the API reports busy
// WAIT_DONE | API busy, waiting for completion
// RESPOND   | one-cycle done/error pulse to the granted requester
module i2c_api_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned CNT_W          = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  i2c_api_arbiter_if.master  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RESPOND} state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q,  state_d;
  logic             grant_q,  grant_d;
  logic             status_q, status_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [6:0]       addr_q,   addr_d;
  logic [7:0]       cmd_q,    cmd_d;
  logic [7:0]       data_q,   data_d;
  logic [7:0]       data2_q,  data2_d;
  logic             dbl_q,    dbl_d;
  logic             win;
  logic             timeout;

  assign timeout = (cnt_q == CNT_LAST);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    status_d = status_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    cmd_d    = cmd_q;
    data_d   = data_q;
    data2_d  = data2_q;
    dbl_d    = dbl_q;
    win      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.api_complete && (bus.r0_req || bus.r1_req)) begin
          // On contention the requester not served last wins.
          win      = (bus.r0_req && bus.r1_req) ? ~grant_q : bus.r1_req;
          grant_d  = win;
          addr_d   = win ? bus.r1_address : bus.r0_address;
          cmd_d    = win ? bus.r1_cmd     : bus.r0_cmd;
          data_d   = win ? bus.r1_data    : bus.r0_data;
          data2_d  = win ? bus.r1_data2   : bus.r0_data2;
          dbl_d    = win ? bus.r1_double  : bus.r0_double;
          cnt_d    = '0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d = cnt_q + 1'b1;
        if (timeout) begin
          status_d = 1'b1;
          state_d  = RESPOND;
        end else if (!bus.api_complete) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        cnt_d = cnt_q + 1'b1;
        // A completion in the timeout cycle counts as a normal completion.
        if (bus.api_complete) begin
          status_d = bus.api_error;
          state_d  = RESPOND;
        end else if (timeout) begin
          status_d = 1'b1;
          state_d  = RESPOND;
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= 1'b1;
      status_q <= 1'b0;
      cnt_q    <= '0;
      addr_q   <= '0;
      cmd_q    <= '0;
      data_q   <= '0;
      data2_q  <= '0;
      dbl_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      status_q <= status_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      cmd_q    <= cmd_d;
      data_q   <= data_d;
      data2_q  <= data2_d;
      dbl_q    <= dbl_d;
    end
  end

  assign bus.api_enable  = (state_q == ISSUE);
  assign bus.api_address = addr_q;
  assign bus.api_cmd     = cmd_q;
  assign bus.api_data    = data_q;
  assign bus.api_data2   = data2_q;
  assign bus.api_double  = dbl_q;
  assign bus.grant       = grant_q;
  assign bus.r0_done     = (state_q == RESPOND) && !grant_q;
  assign bus.r1_done     = (state_q == RESPOND) &&  grant_q;
  assign bus.r0_error    = bus.r0_done && status_q;
  assign bus.r1_error    = bus.r1_done && status_q;

endmodule

// File: tb/tb_i2c_api_arbiter.sv
// Directed self-checking bench for i2c_api_arbiter; the API engine is driven by hand.
module tb_i2c_api_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  i2c_api_arbiter_if bus();

  i2c_api_arbiter #(.TIMEOUT_CYCLES(100), .CNT_W(24)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    bus.r0_req = 0; bus.r0_address = '0; bus.r0_cmd = '0; bus.r0_data = '0;
    bus.r0_data2 = '0; bus.r0_double = 0;
    bus.r1_req = 0; bus.r1_address = '0; bus.r1_cmd = '0; bus.r1_data = '0;
    bus.r1_data2 = '0; bus.r1_double = 0;
    bus.api_complete = 1; bus.api_error = 0;
  endtask

  // Advances until a done pulse is seen or max_cyc edges pass.
  task automatic wait_done(input int max_cyc, output bit seen, output int cyc,
                           output logic d0, output logic d1, output logic e0, output logic e1);
    seen = 0; cyc = 0; d0 = 0; d1 = 0; e0 = 0; e1 = 0;
    for (int i = 1; i <= max_cyc; i++) begin
      tick();
      if (bus.r0_done || bus.r1_done) begin
        seen = 1; cyc = i;
        d0 = bus.r0_done; d1 = bus.r1_done; e0 = bus.r0_error; e1 = bus.r1_error;
        break;
      end
    end
  endtask

  // API engine model: go busy once enabled, stay busy, then complete with err.
  task automatic serve(input int busy, input bit err, output bit en_seen, output bit en_dropped);
    en_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.api_enable) begin
        en_seen = 1;
        break;
      end
      tick();
    end
    bus.api_complete = 0;
    tick();
    en_dropped = !bus.api_enable;
    repeat (busy) tick();
    bus.api_error    = err;
    bus.api_complete = 1;
  endtask

  task automatic test_reset;
    rst_n = 0;
    clear_inputs();
    bus.r0_req = 1;
    repeat (3) tick();
    n_total++;
    if (bus.api_enable !== 1'b0) $display("FAIL reset_enable: got %b expected 0", bus.api_enable);
    else n_pass++;
    n_total++;
    if ({bus.api_address, bus.api_cmd, bus.api_data, bus.api_data2, bus.api_double} !== 32'h0)
      $display("FAIL reset_data: got %h expected 0",
               {bus.api_address, bus.api_cmd, bus.api_data, bus.api_data2, bus.api_double});
    else n_pass++;
    n_total++;
    if ({bus.r0_done, bus.r1_done, bus.r0_error, bus.r1_error} !== 4'b0000)
      $display("FAIL reset_done: got %b expected 0000",
               {bus.r0_done, bus.r1_done, bus.r0_error, bus.r1_error});
    else n_pass++;
    n_total++;
    if (bus.grant !== 1'b1) $display("FAIL reset_grant: got %b expected 1", bus.grant);
    else n_pass++;
    bus.r0_req = 0;
    rst_n = 1;
    tick();
  endtask

  task automatic test_single;
    bit seen; int cyc; logic d0, d1, e0, e1;
    bus.r0_address = 7'h3C; bus.r0_cmd = 8'h00; bus.r0_data = 8'hAF;
    bus.r0_data2 = 8'h55; bus.r0_double = 0; bus.r0_req = 1;
    tick();
    n_total++;
    if (bus.api_enable !== 1'b1) $display("FAIL single_latency: got %b expected 1", bus.api_enable);
    else n_pass++;
    n_total++;
    if ({bus.api_address, bus.api_cmd, bus.api_data, bus.api_double, bus.grant} !== {7'h3C, 8'h00, 8'hAF, 1'b0, 1'b0})
      $display("FAIL single_latch: got %h/%h/%h/%b grant %b expected 3c/00/af/0 grant 0",
               bus.api_address, bus.api_cmd, bus.api_data, bus.api_double, bus.grant);
    else n_pass++;
    bus.r0_address = 7'h11; bus.r0_data = 8'h00;
    repeat (2) tick();
    n_total++;
    if (bus.api_enable !== 1'b1) $display("FAIL single_enable_hold: got %b expected 1", bus.api_enable);
    else n_pass++;
    bus.api_complete = 0;
    tick();
    n_total++;
    if (bus.api_enable !== 1'b0) $display("FAIL single_enable_drop: got %b expected 0", bus.api_enable);
    else n_pass++;
    n_total++;
    if ({bus.api_address, bus.api_data} !== {7'h3C, 8'hAF})
      $display("FAIL single_stable: got %h/%h expected 3c/af", bus.api_address, bus.api_data);
    else n_pass++;
    repeat (39) tick();
    bus.api_complete = 1;
    wait_done(5, seen, cyc, d0, d1, e0, e1);
    bus.r0_req = 0;
    n_total++;
    if ({seen, d0, d1, e0} !== 4'b1100)
      $display("FAIL single_done: got seen=%b r0_done=%b r1_done=%b r0_error=%b expected 1100",
               seen, d0, d1, e0);
    else n_pass++;
    tick();
    n_total++;
    if ({bus.r0_done, bus.r1_done} !== 2'b00)
      $display("FAIL single_one_pulse: got %b expected 00", {bus.r0_done, bus.r1_done});
    else n_pass++;
  endtask

  task automatic test_error;
    bit seen, en_seen, en_drop; int cyc; logic d0, d1, e0, e1;
    bus.r1_address = 7'h50; bus.r1_cmd = 8'hA5; bus.r1_data = 8'h12;
    bus.r1_data2 = 8'h77; bus.r1_double = 1; bus.r1_req = 1;
    tick();
    n_total++;
    if ({bus.api_address, bus.api_cmd, bus.api_data, bus.api_data2, bus.api_double, bus.grant}
        !== {7'h50, 8'hA5, 8'h12, 8'h77, 1'b1, 1'b1})
      $display("FAIL error_latch: got %h/%h/%h/%h/%b grant %b expected 50/a5/12/77/1 grant 1",
               bus.api_address, bus.api_cmd, bus.api_data, bus.api_data2, bus.api_double, bus.grant);
    else n_pass++;
    serve(5, 1'b1, en_seen, en_drop);
    wait_done(5, seen, cyc, d0, d1, e0, e1);
    bus.r1_req = 0;
    n_total++;
    if ({seen, d0, d1, e0, e1} !== 5'b10101)
      $display("FAIL error_done: got seen=%b r0_done=%b r1_done=%b r0_error=%b r1_error=%b expected 10101",
               seen, d0, d1, e0, e1);
    else n_pass++;
    bus.api_error = 0;
    tick();
  endtask

  task automatic test_back_to_back;
    bit seen, en_seen, en_drop; int cyc; logic d0, d1, e0, e1;
    logic [1:0] exp_who;
    logic [6:0] exp_addr;
    rst_n = 0;
    bus.r0_address = 7'h10; bus.r1_address = 7'h20;
    bus.r0_req = 1; bus.r1_req = 1;
    repeat (2) tick();
    rst_n = 1;
    for (int k = 0; k < 4; k++) begin
      exp_who  = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_addr = (k % 2 == 0) ? 7'h10 : 7'h20;
      serve(3, 1'b0, en_seen, en_drop);
      wait_done(10, seen, cyc, d0, d1, e0, e1);
      n_total++;
      if ({seen, d1, d0, bus.api_address} !== {1'b1, exp_who, exp_addr})
        $display("FAIL order_%0d: got seen=%b r1r0_done=%b addr=%h expected 1 %b %h",
                 k, seen, {d1, d0}, bus.api_address, exp_who, exp_addr);
      else n_pass++;
      tick();
      n_total++;
      if ({bus.r0_done, bus.r1_done} !== 2'b00)
        $display("FAIL order_pulse_%0d: got %b expected 00", k, {bus.r0_done, bus.r1_done});
      else n_pass++;
    end
    bus.r0_req = 0; bus.r1_req = 0;
    repeat (3) tick();
  endtask

  task automatic test_timeout;
    bit seen; int cyc; logic d0, d1, e0, e1; int bad;
    bus.r0_req = 1;
    tick();
    bus.api_complete = 0;
    wait_done(150, seen, cyc, d0, d1, e0, e1);
    n_total++;
    if ({seen, d0, d1, e0} !== 4'b1101 || cyc != 100)
      $display("FAIL timeout_done: got seen=%b r0_done=%b r1_done=%b r0_error=%b cycles=%0d expected 1101 at 100",
               seen, d0, d1, e0, cyc);
    else n_pass++;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.api_enable !== 1'b0) bad++;
      if (i > 0 && (bus.r0_done !== 1'b0 || bus.r1_done !== 1'b0)) bad++;
      tick();
    end
    n_total++;
    if (bad != 0) $display("FAIL timeout_after: got %0d bad cycles expected 0", bad);
    else n_pass++;
    bus.r0_req = 0;
    bus.api_complete = 1;
    repeat (2) tick();
  endtask

  task automatic test_timeout_race;
    bit seen; int cyc; logic d0, d1, e0, e1;
    bus.r1_req = 1;
    tick();
    bus.api_complete = 0;
    repeat (99) tick();
    bus.api_complete = 1;
    bus.api_error = 0;
    wait_done(3, seen, cyc, d0, d1, e0, e1);
    bus.r1_req = 0;
    n_total++;
    if ({seen, d1, e1} !== 3'b110 || cyc != 1)
      $display("FAIL race_done: got seen=%b r1_done=%b r1_error=%b cycles=%0d expected 110 at 1",
               seen, d1, e1, cyc);
    else n_pass++;
    repeat (2) tick();
  endtask

  task automatic test_reset_mid;
    bit seen, en_seen, en_drop; int cyc; logic d0, d1, e0, e1; int bad;
    bus.r0_address = 7'h2A; bus.r0_data = 8'h99; bus.r0_req = 1;
    tick();
    bus.api_complete = 0;
    repeat (4) tick();
    rst_n = 0;
    bus.r0_req = 0;
    tick();
    rst_n = 1;
    n_total++;
    if ({bus.api_enable, bus.api_address, bus.api_data, bus.grant, bus.r0_done, bus.r1_done}
        !== {1'b0, 7'h00, 8'h00, 1'b1, 1'b0, 1'b0})
      $display("FAIL midreset_outputs: got en=%b addr=%h data=%h grant=%b done=%b%b expected 0/00/00/1/00",
               bus.api_enable, bus.api_address, bus.api_data, bus.grant, bus.r0_done, bus.r1_done);
    else n_pass++;
    bus.api_complete = 1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.r0_done !== 1'b0 || bus.r1_done !== 1'b0) bad++;
    end
    n_total++;
    if (bad != 0) $display("FAIL midreset_no_done: got %0d pulses expected 0", bad);
    else n_pass++;
    bus.r0_req = 1; bus.r1_req = 1;
    tick();
    serve(2, 1'b0, en_seen, en_drop);
    wait_done(10, seen, cyc, d0, d1, e0, e1);
    bus.r0_req = 0; bus.r1_req = 0;
    n_total++;
    if ({seen, d0, d1} !== 3'b110)
      $display("FAIL midreset_grant: got seen=%b r0_done=%b r1_done=%b expected 110", seen, d0, d1);
    else n_pass++;
    repeat (2) tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_error();
    test_back_to_back();
    test_timeout();
    test_timeout_race();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
